hazard_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the IF/ID and ID/EX boundaries around the decode stage.
- Detects load-use hazards on the instruction held in IF/ID and flushes wrong-path instructions on taken branches/jumps resolved in EX.
- Freezes the front end during multi-cycle MDU (mul/div) operations.
- Emits stall, flush and bubble controls plus two performance counters.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_detect.sv | 47 ++++
 rtl/hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard controller:
// FSM state encodings and the RV32 opcodes relevant to operand use.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection for the instruction held in IF/ID
// against the load sitting in ID/EX.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int data_width = 32
) (
  input  logic [data_width-1:0] instr,
  input  logic                  id_ex_valid,
  input  logic                  id_ex_mem_read,
  input  logic [4:0]            id_ex_rd,
  output logic                  lu
);

  logic [6:0] opcode_s;
  logic [4:0] rs1_s;
  logic [4:0] rs2_s;
  logic       uses_rs1_s;
  logic       uses_rs2_s;
  logic       unused_bits_s;

  assign opcode_s      = instr[6:0];
  assign rs1_s         = instr[19:15];
  assign rs2_s         = instr[24:20];
  assign unused_bits_s = ^{instr[data_width-1:25], instr[14:7]};

  // Operand usage by opcode, then the hazard match itself.
  always_comb begin
    uses_rs1_s = 1'b1;
    uses_rs2_s = 1'b0;
    lu         = 1'b0;
    case (opcode_s)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1_s = 1'b0;
      OP_R, OP_STORE, OP_BRANCH: uses_rs2_s = 1'b1;
      default: begin
        uses_rs1_s = 1'b1;
        uses_rs2_s = 1'b0;
      end
    endcase
    if (id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0)) begin
      lu = (uses_rs1_s && (rs1_s == id_ex_rd)) || (uses_rs2_s && (rs2_s == id_ex_rd));
    end else begin
      lu = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble sequencing around the decode stage: load-use stalls,
// taken-branch flushes, MDU front-end freeze and two saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int data_width   = 32,
  parameter int MDU_LATENCY  = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] instr_reg_fetch,
  input  logic                  id_ex_valid,
  input  logic                  id_ex_mem_read,
  input  logic [4:0]            id_ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mdu_start,
  input  logic                  mdu_done,
  input  logic                  cnt_clr,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_stall,
  output logic                  idex_bubble,
  output logic [1:0]            ctrl_state,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int MCW = $clog2(MDU_LATENCY + 1);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  state_e           state_q, state_d;
  logic [MCW-1:0]   mcnt_q, mcnt_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic lu_s;
  logic pc_stall_s, ifid_stall_s, ifid_flush_s, idex_stall_s, idex_bubble_s;
  logic flush_inc_s;

  hazard_detect #(.data_width(data_width)) u_detect (
    .instr          (instr_reg_fetch),
    .id_ex_valid    (id_ex_valid),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .lu             (lu_s)
  );

  // Next-state and raw controls; RUN is Mealy, the wait states are Moore.
  always_comb begin
    state_d       = state_q;
    mcnt_d        = mcnt_q;
    fcnt_d        = fcnt_q;
    pc_stall_s    = 1'b0;
    ifid_stall_s  = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_stall_s  = 1'b0;
    idex_bubble_s = 1'b0;
    flush_inc_s   = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          flush_inc_s   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCW'(FLUSH_CYCLES - 1);
          end else begin
            state_d = RUN;
          end
        end else if (ex_mdu_start) begin
          pc_stall_s   = 1'b1;
          ifid_stall_s = 1'b1;
          idex_stall_s = 1'b1;
          state_d      = MDU_WAIT;
          mcnt_d       = MCW'(MDU_LATENCY - 1);
        end else if (lu_s) begin
          pc_stall_s    = 1'b1;
          ifid_stall_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MDU_WAIT: begin
        pc_stall_s   = 1'b1;
        ifid_stall_s = 1'b1;
        idex_stall_s = 1'b1;
        if ((mcnt_q == MCW'(1)) || mdu_done) begin
          state_d = RUN;
          mcnt_d  = '0;
        end else begin
          mcnt_d = mcnt_q - MCW'(1);
        end
      end
      FLUSH: begin
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
        if (ex_branch_taken) begin
          fcnt_d      = FCW'(FLUSH_CYCLES - 1);
          flush_inc_s = 1'b1;
        end else if (fcnt_q == FCW'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: begin
        state_d = RUN;
        mcnt_d  = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  // Controls are held low for the whole time reset is asserted.
  always_comb begin
    if (rst) begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_bubble = 1'b0;
    end else begin
      pc_stall    = pc_stall_s;
      ifid_stall  = ifid_stall_s;
      ifid_flush  = ifid_flush_s;
      idex_stall  = idex_stall_s;
      idex_bubble = idex_bubble_s;
    end
  end

  // Saturating perf counters; clear wins over increment.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (cnt_clr) begin
      stall_cycles_d = '0;
      flush_events_d = '0;
    end else begin
      if (pc_stall && !(&stall_cycles_q)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end else begin
        stall_cycles_d = stall_cycles_q;
      end
      if (flush_inc_s && !(&flush_events_q)) begin
        flush_events_d = flush_events_q + CNT_W'(1);
      end else begin
        flush_events_d = flush_events_q;
      end
    end
  end

  // State, sequencing counters and perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      mcnt_q         <= '0;
      fcnt_q         <= '0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      mcnt_q         <= mcnt_d;
      fcnt_q         <= fcnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign ctrl_state   = state_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized bench for hazard_ctrl, checked every cycle
// against a cycle-budget reference model of the controller.
module tb_hazard_ctrl;

  localparam int ML   = 8;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instr_reg_fetch;
  logic          id_ex_valid, id_ex_mem_read;
  logic [4:0]    id_ex_rd;
  logic          ex_branch_taken, ex_mdu_start, mdu_done, cnt_clr;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_cycles, flush_events;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining freeze / flush cycles and counter values.
  int freeze_left = 0;
  int flush_left  = 0;
  int m_sc        = 0;
  int m_fe        = 0;

  hazard_ctrl #(.data_width(32), .MDU_LATENCY(ML), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_reg_fetch(instr_reg_fetch),
    .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .cnt_clr(cnt_clr), .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_bubble(idex_bubble), .ctrl_state(ctrl_state),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    int op, r1, r2;
    bit need1, need2;
    op    = int'(instr_reg_fetch) & 127;
    r1    = (int'(instr_reg_fetch) >> 15) & 31;
    r2    = (int'(instr_reg_fetch) >> 20) & 31;
    need1 = !(op == 55 || op == 23 || op == 111);
    need2 = (op == 51 || op == 35 || op == 99);
    return id_ex_valid && id_ex_mem_read && (id_ex_rd != 0) &&
           ((need1 && r1 == int'(id_ex_rd)) || (need2 && r2 == int'(id_ex_rd)));
  endfunction

  // One cycle: check outputs at the falling edge, advance the model, land just after the rising edge.
  task automatic step();
    bit ps, is_, fl, xs, bb, br_ev;
    int exp_state;
    @(negedge clk);
    {ps, is_, fl, xs, bb, br_ev} = '0;
    exp_state = (freeze_left > 0) ? 1 : ((flush_left > 0) ? 2 : 0);
    if (!rst) begin
      if (freeze_left > 0) begin
        {ps, is_, xs} = 3'b111;
      end else if (flush_left > 0) begin
        {fl, bb} = 2'b11;
        br_ev = ex_branch_taken;
      end else if (ex_branch_taken) begin
        {fl, bb} = 2'b11;
        br_ev = 1'b1;
      end else if (ex_mdu_start) begin
        {ps, is_, xs} = 3'b111;
      end else if (model_lu()) begin
        {ps, is_, bb} = 3'b111;
      end
    end
    check_val("ctrl", {27'd0, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_bubble},
              {27'd0, ps, is_, fl, xs, bb});
    check_val("state", {30'd0, ctrl_state}, exp_state);
    check_val("stall_cycles", {28'd0, stall_cycles}, m_sc);
    check_val("flush_events", {28'd0, flush_events}, m_fe);
    if (rst) begin
      freeze_left = 0; flush_left = 0; m_sc = 0; m_fe = 0;
    end else begin
      if (freeze_left > 0) begin
        freeze_left = (mdu_done || freeze_left == 1) ? 0 : freeze_left - 1;
      end else if (flush_left > 0) begin
        flush_left = ex_branch_taken ? FC - 1 : flush_left - 1;
      end else if (ex_branch_taken) begin
        flush_left = FC - 1;
      end else if (ex_mdu_start) begin
        freeze_left = ML - 1;
      end
      if (cnt_clr) begin
        m_sc = 0; m_fe = 0;
      end else begin
        if (ps && m_sc < CMAX) m_sc++;
        if (br_ev && m_fe < CMAX) m_fe++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; instr_reg_fetch = 32'h0000_0013; id_ex_valid = 1'b0; id_ex_mem_read = 1'b0;
    id_ex_rd = 5'd0; ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] ins);
    id_ex_valid = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = rd; instr_reg_fetch = ins;
  endtask

  initial begin
    int ops[8] = '{55, 23, 111, 51, 35, 99, 3, 19};
    logic [31:0] ins;
    idle();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check_val("reset_cnt", {28'd0, stall_cycles}, 32'd0);

    // Load-use on rs1, released by the bubble.
    set_load(5'd5, 32'h0072_8333);
    step();
    id_ex_valid = 1'b0;
    step();
    check_val("lu_cnt", {28'd0, stall_cycles}, 32'd1);

    // False hazards: LUI ignores rs1; x0 destination never hazards.
    set_load(5'd5, 32'h0002_8337);
    step();
    set_load(5'd0, 32'h0070_0333);
    step();
    check_val("false_hz_cnt", {28'd0, stall_cycles}, 32'd1);
    idle();

    // Taken branch: two flush cycles.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    ex_branch_taken = 1'b1; step(); ex_branch_taken = 1'b0;
    step(); step();
    check_val("br_events", {28'd0, flush_events}, 32'd1);
    check_val("br_state", {30'd0, ctrl_state}, 32'd0);

    // Branch with simultaneous load-use: flush wins.
    set_load(5'd5, 32'h0072_8333);
    ex_branch_taken = 1'b1; step(); idle();
    step(); step();
    check_val("br_lu_stall", {28'd0, stall_cycles}, 32'd0);

    // Full-length MDU freeze.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    ex_mdu_start = 1'b1; step(); ex_mdu_start = 1'b0;
    repeat (8) step();
    check_val("mdu_cnt", {28'd0, stall_cycles}, 32'd8);

    // Early MDU exit on the third wait cycle.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    ex_mdu_start = 1'b1; step(); ex_mdu_start = 1'b0;
    step(); step();
    mdu_done = 1'b1; step(); mdu_done = 1'b0;
    step();
    check_val("mdu_early", {28'd0, stall_cycles}, 32'd4);

    // Reset in the middle of an MDU wait.
    ex_mdu_start = 1'b1; step(); ex_mdu_start = 1'b0;
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    step();
    check_val("rst_mid_state", {30'd0, ctrl_state}, 32'd0);
    check_val("rst_mid_cnt", {28'd0, stall_cycles}, 32'd0);

    // Saturation after 24 stall cycles, then clear racing an increment.
    repeat (3) begin
      ex_mdu_start = 1'b1; step(); ex_mdu_start = 1'b0;
      repeat (7) step();
    end
    check_val("sat_cnt", {28'd0, stall_cycles}, 32'd15);
    cnt_clr = 1'b1; ex_mdu_start = 1'b1; step();
    cnt_clr = 1'b0; ex_mdu_start = 1'b0;
    check_val("clr_pri", {28'd0, stall_cycles}, 32'd0);
    repeat (7) step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom;
      ins[6:0] = 7'(ops[$urandom_range(0, 7)]);
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      instr_reg_fetch = ins;
      id_ex_valid     = ($urandom_range(0, 3) != 0);
      id_ex_mem_read  = ($urandom_range(0, 1) != 0);
      id_ex_rd        = 5'($urandom_range(0, 7));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      ex_mdu_start    = ($urandom_range(0, 11) == 0);
      mdu_done        = ($urandom_range(0, 9) == 0);
      cnt_clr         = ($urandom_range(0, 63) == 0);
      rst             = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
